fht_seq_ctrl: RTL and testbench
===============================

Name: fht_seq_ctrl

Overview:
- Parametrised successor to the fixed-size FHT control block.
- Generates shared bank read/write addresses, twiddle-coefficient addresses, ping-pong bank-set selects and stage flags for an in-place radix-2 FHT.
- Point count N = 2^L is selected at run time; BANKS parallel memory banks each hold N/BANKS points.
- Sits between the top-level start/ready handshake and the butterfly datapath / coefficient ROM.

Parameters:
A_BIT, 8, per-bank address width; bank depth 2^A_BIT
BANKS, 4, number of parallel banks; power of two, >=2; LB = log2(BANKS)
BF_LAT, 3, butterfly pipeline latency in cycles from read address to write address, >=1
LW, $clog2(A_BIT+LB+1), width of iLOG2N

Ports:
iCLK  in  1  clock, all logic on rising edge
iRESET  in  1  asynchronous, active-high reset
iSTART  in  1  start pulse; sampled only in IDLE
iLOG2N  in  LW  L = log2(N); latched at accepted start
oRD_EN  out  1  read address valid this cycle
oADDR_RD  out  A_BIT  read address, common to all banks
oADDR_WR  out  A_BIT  write address, common to all banks
oADDR_COEF  out  A_BIT  twiddle ROM address
oWE_A  out  1  write strobe, bank set A
oWE_B  out  1  write strobe, bank set B
oSRC_B  out  1  0: stage reads set A; 1: stage reads set B
oSTAGE  out  LW  current stage s
oST_ZERO  out  1  s==0 while busy
oST_LAST  out  1  s==L-1 while busy
oERR  out  1  one-cycle pulse, rejected start
oDONE  out  1  one-cycle pulse after last write
oRDY  out  1  idle and ready for a start

Behaviour:
- Reset values: oRDY=1; every other output 0. Reset is asynchronous and abandons any transform; pending writes are discarded.
- Legal L range: LB+1 <= L <= A_BIT+LB. D = 2^(L-LB) cycles per stage.
- Start acceptance: in IDLE, iSTART=1 with L out of range -> oERR pulses next cycle, state stays IDLE. iSTART is ignored while busy.
- FSM IDLE -> READ: on a legal start, oRDY drops on the next edge. Counter c=0, s=0, and the first read is presented in the same cycle.
- READ: oRD_EN=1 for D cycles, c = 0..D-1, then -> DRAIN.
- DRAIN: BF_LAT cycles with oRD_EN=0, waiting for in-flight writes.
- End of DRAIN: if s<L-1, s++ and -> READ with c=0; otherwise -> DONE.
- DONE: one cycle; oDONE=1, oRDY=1 from the following cycle; -> IDLE.
- Total busy time: L*(D+BF_LAT) cycles, then 1 DONE cycle.
- Read address, stage s, t = s-LB:
  - s < LB: oADDR_RD = c; butterfly partners are in different banks.
  - s >= LB: oADDR_RD = c with bit 0 moved to bit position t; bits 1..t shift down by one; bits above t unchanged.
  - For t=0 this is the identity.
- Coefficient address:
  - s < LB: 0.
  - s >= LB, t > 0: low t bits of oADDR_RD, shifted left by (A_BIT-t), truncated to A_BIT bits.
  - t = 0: 0.
  - oADDR_COEF is aligned with oADDR_RD, not delayed.
- Writes: oADDR_WR and the write strobe are the read address and oRD_EN delayed exactly BF_LAT cycles (shift pipeline). The pipeline is cleared only by reset.
- Ping-pong: even s reads A and writes B (oSRC_B=0, oWE_B); odd s reads B and writes A (oSRC_B=1, oWE_A). oWE_A and oWE_B are never high together.
- oSRC_B, oSTAGE and the flags update on the same edge as the first read of the stage and hold through DRAIN.
- Final result lands in set B if L is odd, set A if L is even.
- Counter wrap: c is A_BIT+1 bits wide internally, so D = 2^A_BIT does not overflow.

Optional Feature:
FHT_ABORT_EN
- With the macro: adds port iABORT (in, 1). iABORT=1 in READ or DRAIN -> IDLE on the next edge. oRD_EN and both WE strobes are forced 0 from that edge and the write pipeline is flushed. oRDY=1 the following cycle; no oDONE pulse. In IDLE or DONE, iABORT has no effect.
- Without the macro: the port does not exist and a transform always runs to completion.

Test Plan:
- A_BIT=4, BANKS=4, BF_LAT=3, iLOG2N=6, start -> D=16; 6 stages of 19 cycles; oDONE exactly 114 cycles after the first oRD_EN; oRDY high one cycle later; final writes on oWE_B=0, oWE_A=1 (L even).
- Same config, stage 3 (t=1) -> oADDR_RD sequence 0,2,1,3,4,6,5,7,...; oADDR_WR equals that sequence 3 cycles later; oADDR_COEF 0,0,8,8,0,0,8,8,...
- Stage 5 (t=3) -> c=1,2,3 give oADDR_RD 8,1,9 and oADDR_COEF 0,2,2.
- iLOG2N=2 or 7 with iSTART -> oERR one-cycle pulse, oRDY stays 1, no oRD_EN.
- Assert iRESET mid-stage 2 -> all outputs reach reset values immediately, no writes afterwards; a new start with iLOG2N=3 (D=2) completes in 3*5 = 15 busy cycles.
- FHT_ABORT_EN defined: iABORT during the DRAIN of stage 1 -> no WE strobes from the next edge, oRDY=1 one cycle later, no oDONE pulse.

Source files
------------

// File: rtl/fht_seq_ctrl.sv
// rtl/fht_seq_ctrl.sv - sequencer for an in-place radix-2 FHT over BANKS parallel memory banks
//
// Purpose: steps an N = 2^L point transform through L stages and generates the
// shared bank read/write addresses, twiddle ROM addresses, ping-pong bank-set
// strobes and stage flags. Each stage reads for D = 2^(L-LB) cycles, then drains
// for BF_LAT cycles while the butterfly pipeline empties.
//
// Optional build macro: FHT_ABORT_EN adds iABORT, which cancels a running transform.
//
// Ports:
//   iCLK, iRESET          clock (rising edge), asynchronous active-high reset
//   iSTART, iLOG2N        start pulse and L, both taken only while idle
//   iABORT                cancel a running transform (FHT_ABORT_EN builds only)
//   oRD_EN, oADDR_RD      read valid and read address, common to all banks
//   oADDR_COEF            twiddle ROM address, aligned with oADDR_RD
//   oADDR_WR, oWE_A/B     write address and per-set write strobes, BF_LAT behind the read
//   oSRC_B                set the current stage reads from (0: A, 1: B)
//   oSTAGE, oST_ZERO/LAST current stage and first/last stage flags
//   oERR, oDONE, oRDY     rejected-start pulse, completion pulse, idle indication
module fht_seq_ctrl #(
  parameter int A_BIT  = 8,
  parameter int BANKS  = 4,
  parameter int BF_LAT = 3,
  parameter int LW     = $clog2(A_BIT + $clog2(BANKS) + 1)
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic [LW-1:0]    iLOG2N,
`ifdef FHT_ABORT_EN
  input  logic             iABORT,
`endif
  output logic             oRD_EN,
  output logic [A_BIT-1:0] oADDR_RD,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [A_BIT-1:0] oADDR_COEF,
  output logic             oWE_A,
  output logic             oWE_B,
  output logic             oSRC_B,
  output logic [LW-1:0]    oSTAGE,
  output logic             oST_ZERO,
  output logic             oST_LAST,
  output logic             oERR,
  output logic             oDONE,
  output logic             oRDY
);

  localparam int LB = $clog2(BANKS);
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [A_BIT:0] ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [A_BIT:0]   c;          // one bit wider so D = 2^A_BIT fits
  logic [A_BIT:0]   d_len;
  logic [LW-1:0]    s, l_reg;
  logic [DW-1:0]    dcnt;
  logic             err_q;
  logic             legal, start_ok, start_bad, abort, busy;
  logic             last_rd, last_dr, last_st;
  logic [A_BIT-1:0] perm, coef;
  logic             rd_pipe  [BF_LAT];
  logic             src_pipe [BF_LAT];
  logic [A_BIT-1:0] wa_pipe  [BF_LAT];

`ifdef FHT_ABORT_EN
  assign abort = iABORT;
`else
  assign abort = 1'b0;
`endif

  assign legal     = (int'(iLOG2N) >= LB + 1) && (int'(iLOG2N) <= A_BIT + LB);
  assign start_ok  = (state == S_IDLE) && iSTART && legal;
  assign start_bad = (state == S_IDLE) && iSTART && !legal;
  assign busy      = (state == S_READ) || (state == S_DRAIN);
  assign d_len     = ONE << (l_reg - LW'(LB));
  assign last_rd   = (c == d_len - ONE);
  assign last_dr   = (dcnt == DW'(BF_LAT - 1));
  assign last_st   = (s == l_reg - LW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_READ;
      S_READ:  if (abort) state_nxt = S_IDLE;
               else if (last_rd) state_nxt = S_DRAIN;
      S_DRAIN: if (abort) state_nxt = S_IDLE;
               else if (last_dr) state_nxt = last_st ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Below LB the butterfly partners sit in different banks, so the counter is the
  // address. From stage LB on, partners share a bank: counter bit 0 is moved up
  // to bit t so consecutive reads fetch the two halves of one butterfly.
  always_comb begin
    int t;
    t    = int'(s) - LB;
    perm = c[A_BIT-1:0];
    coef = '0;
    if (t >= 0) begin
      for (int i = 0; i < A_BIT; i++) begin
        if (i < t)       perm[i] = c[i+1];
        else if (i == t) perm[i] = c[0];
      end
    end
    if (t > 0) begin
      for (int i = 0; i < A_BIT; i++)
        if (i >= A_BIT - t) coef[i] = perm[i - (A_BIT - t)];
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= S_IDLE;
      c     <= '0;
      s     <= '0;
      l_reg <= '0;
      dcnt  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < BF_LAT; i++) begin
        rd_pipe[i]  <= 1'b0;
        src_pipe[i] <= 1'b0;
        wa_pipe[i]  <= '0;
      end
    end else begin
      state <= state_nxt;
      err_q <= start_bad;
      c     <= (state == S_READ && state_nxt == S_READ) ? c + ONE : '0;
      dcnt  <= (state == S_DRAIN && state_nxt == S_DRAIN) ? dcnt + DW'(1) : '0;
      if (start_ok) begin
        l_reg <= iLOG2N;
        s     <= '0;
      end else if (state == S_DRAIN && state_nxt == S_READ) begin
        s <= s + LW'(1);
      end
      if (busy && abort) begin
        for (int i = 0; i < BF_LAT; i++) begin
          rd_pipe[i]  <= 1'b0;
          src_pipe[i] <= 1'b0;
          wa_pipe[i]  <= '0;
        end
      end else begin
        rd_pipe[0]  <= oRD_EN;
        src_pipe[0] <= oSRC_B;
        wa_pipe[0]  <= oADDR_RD;
        for (int i = 1; i < BF_LAT; i++) begin
          rd_pipe[i]  <= rd_pipe[i-1];
          src_pipe[i] <= src_pipe[i-1];
          wa_pipe[i]  <= wa_pipe[i-1];
        end
      end
    end
  end

  assign oRD_EN     = (state == S_READ);
  assign oADDR_RD   = oRD_EN ? perm : '0;
  assign oADDR_COEF = oRD_EN ? coef : '0;
  assign oSRC_B     = busy & s[0];
  assign oSTAGE     = busy ? s : '0;
  assign oST_ZERO   = busy && (s == '0);
  assign oST_LAST   = busy && last_st;
  // The set bit travels with the write so a stage's last writes, which land in
  // its final drain cycle, still hit the set chosen when they were read.
  assign oADDR_WR   = wa_pipe[BF_LAT-1];
  assign oWE_A      = rd_pipe[BF_LAT-1] & src_pipe[BF_LAT-1];
  assign oWE_B      = rd_pipe[BF_LAT-1] & ~src_pipe[BF_LAT-1];
  assign oERR       = err_q;
  assign oDONE      = (state == S_DONE);
  assign oRDY       = (state == S_IDLE);

endmodule

// File: tb/tb_fht_seq_ctrl.sv
// tb/tb_fht_seq_ctrl.sv - directed self-checking bench for fht_seq_ctrl
module tb_fht_seq_ctrl;
  localparam int A_BIT = 4;
  localparam int BANKS = 4;
  localparam int BF_LAT = 3;
  localparam int LW = 3;
  localparam int NCAP = 130;

  logic             iCLK = 1'b0;
  logic             iRESET = 1'b1;
  logic             iSTART = 1'b0;
  logic [LW-1:0]    iLOG2N = '0;
`ifdef FHT_ABORT_EN
  logic             iABORT = 1'b0;
`endif
  logic             oRD_EN, oWE_A, oWE_B, oSRC_B, oST_ZERO, oST_LAST, oERR, oDONE, oRDY;
  logic [A_BIT-1:0] oADDR_RD, oADDR_WR, oADDR_COEF;
  logic [LW-1:0]    oSTAGE;

  int n_chk = 0;
  int n_pass = 0;
  int rd[NCAP], ar[NCAP], cf[NCAP], aw[NCAP], wa[NCAP], wb[NCAP];
  int dn[NCAP], ry[NCAP], st[NCAP], sb[NCAP], sz[NCAP], sl[NCAP];
  int seq3[8] = '{0, 2, 1, 3, 4, 6, 5, 7};
  int cof3[8] = '{0, 0, 8, 8, 0, 0, 8, 8};
  int k0;

  fht_seq_ctrl #(.A_BIT(A_BIT), .BANKS(BANKS), .BF_LAT(BF_LAT), .LW(LW)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iLOG2N(iLOG2N),
`ifdef FHT_ABORT_EN
    .iABORT(iABORT),
`endif
    .oRD_EN(oRD_EN), .oADDR_RD(oADDR_RD), .oADDR_WR(oADDR_WR), .oADDR_COEF(oADDR_COEF),
    .oWE_A(oWE_A), .oWE_B(oWE_B), .oSRC_B(oSRC_B), .oSTAGE(oSTAGE),
    .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST), .oERR(oERR), .oDONE(oDONE), .oRDY(oRDY)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Sample every negedge; k=0 is the first cycle after the start edge.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge iCLK);
      iSTART = 1'b0;
`ifdef FHT_ABORT_EN
      iABORT = 1'b0;
`endif
      rd[k] = oRD_EN;  ar[k] = oADDR_RD;  cf[k] = oADDR_COEF; aw[k] = oADDR_WR;
      wa[k] = oWE_A;   wb[k] = oWE_B;     dn[k] = oDONE;      ry[k] = oRDY;
      st[k] = oSTAGE;  sb[k] = oSRC_B;    sz[k] = oST_ZERO;   sl[k] = oST_LAST;
    end
  endtask

  task automatic start(input int l);
    @(negedge iCLK);
    iSTART = 1'b1;
    iLOG2N = LW'(l);
  endtask

  function automatic int first_done(input int n);
    for (int k = 0; k < n; k++) if (dn[k] != 0) return k;
    return -1;
  endfunction

  function automatic int count(input int n, input int which);
    int sum = 0;
    for (int k = 0; k < n; k++)
      case (which)
        0: sum += rd[k];
        1: sum += wa[k];
        2: sum += wb[k];
        3: sum += wa[k] & wb[k];
        default: sum += dn[k];
      endcase
    return sum;
  endfunction

  function automatic int out_vec();
    return int'({oRD_EN, oADDR_RD, oADDR_WR, oADDR_COEF, oWE_A, oWE_B, oSRC_B,
                 oSTAGE, oST_ZERO, oST_LAST, oERR, oDONE});
  endfunction

  initial begin
    #12;
    check("reset_rdy", oRDY, 1);
    check("reset_outs", out_vec(), 0);
    @(negedge iCLK);
    iRESET = 1'b0;

    // Full L=6 transform: D=16, 6 stages of 19 cycles.
    start(6);
    capture(NCAP);
    check("first_rd", rd[0], 1);
    check("st_zero_k0", sz[0], 1);
    check("done_at", first_done(NCAP), 114);
    check("rdy_in_done", ry[114], 0);
    check("rdy_after_done", ry[115], 1);
    check("rd_count", count(NCAP, 0), 96);
    check("wa_count", count(NCAP, 1), 48);
    check("wb_count", count(NCAP, 2), 48);
    check("we_overlap", count(NCAP, 3), 0);
    check("done_width", count(NCAP, 4), 1);
    check("first_wr_b", wb[3], 1);
    check("first_wr_addr", aw[3], 0);
    k0 = 3 * 19;
    check("s3_stage", st[k0], 3);
    check("s3_src_b", sb[k0], 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s3_rd%0d", i), ar[k0+i], seq3[i]);
      check($sformatf("s3_cf%0d", i), cf[k0+i], cof3[i]);
      check($sformatf("s3_wr%0d", i), aw[k0+3+i], seq3[i]);
      check($sformatf("s3_wea%0d", i), wa[k0+3+i], 1);
    end
    k0 = 5 * 19;
    check("s5_last", sl[k0], 1);
    check("s5_rd1", ar[k0+1], 8);
    check("s5_rd2", ar[k0+2], 1);
    check("s5_rd3", ar[k0+3], 9);
    check("s5_cf1", cf[k0+1], 0);
    check("s5_cf2", cf[k0+2], 2);
    check("s5_cf3", cf[k0+3], 2);
    check("s5_drain_rd", rd[111], 0);
    check("s5_drain_last", sl[111], 1);
    check("last_wr_a", wa[113], 1);
    check("last_wr_b", wb[113], 0);
    check("no_wr_done", wa[114] + wb[114], 0);

    // Out-of-range L rejected.
    for (int j = 0; j < 2; j++) begin
      start(j == 0 ? 2 : 7);
      @(negedge iCLK);
      iSTART = 1'b0;
      check($sformatf("err_pulse_%0d", j), oERR, 1);
      check($sformatf("err_rdy_%0d", j), oRDY, 1);
      check($sformatf("err_rd_%0d", j), oRD_EN, 0);
      @(negedge iCLK);
      check($sformatf("err_end_%0d", j), oERR, 0);
      check($sformatf("err_idle_%0d", j), oRD_EN, 0);
    end

    // Reset mid stage 2.
    start(6);
    capture(43);
    check("mid_stage", st[42], 2);
    @(negedge iCLK);
    iRESET = 1'b1;
    #1;
    check("arst_rdy", oRDY, 1);
    check("arst_outs", out_vec(), 0);
    @(negedge iCLK);
    iRESET = 1'b0;
    capture(6);
    check("post_rst_we", count(6, 1) + count(6, 2), 0);
    check("post_rst_rd", count(6, 0), 0);

    // Short L=3: D=2, 3*5 busy cycles, result in set B.
    start(3);
    capture(20);
    check("l3_done_at", first_done(20), 15);
    check("l3_rd_count", count(20, 0), 6);
    check("l3_last_wb", wb[14], 1);
    check("l3_rdy", ry[16], 1);

`ifdef FHT_ABORT_EN
    // Abort during the drain of stage 1 (cycles 35..37).
    start(6);
    capture(36);
    check("ab_in_drain", rd[35] == 0 && st[35] == 1, 1);
    iABORT = 1'b1;
    capture(20);
    check("ab_no_we", wa[0] + wb[0], 0);
    check("ab_no_rd", rd[0], 0);
    check("ab_rdy", ry[0], 1);
    check("ab_no_we_later", count(20, 1) + count(20, 2), 0);
    check("ab_no_done", count(20, 4), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
